// File: rtl/ccd_timing_pkg.sv
// Shared configuration record, reset defaults and load validation for the
// CCD/AFE timing generator.
package ccd_timing_pkg;

  localparam int CFG_CNT_W  = 8;
  localparam int CFG_LINE_W = 16;
  localparam int CFG_NUM_CH = 6;

  typedef struct packed {
    logic [CFG_CNT_W-1:0]                 period;
    logic [CFG_NUM_CH-1:0][CFG_CNT_W-1:0] rise;
    logic [CFG_NUM_CH-1:0][CFG_CNT_W-1:0] fall;
    logic [CFG_NUM_CH-1:0]                pol;
    logic [CFG_NUM_CH-1:0]                hold;
    logic [CFG_LINE_W-1:0]                line_len;
    logic [CFG_LINE_W-1:0]                sh_len;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    period:   CFG_CNT_W'(4),
    rise:     '0,
    fall:     '0,
    pol:      '0,
    hold:     '0,
    line_len: CFG_LINE_W'(2),
    sh_len:   CFG_LINE_W'(1)
  };

  // Every edge must land inside the period and SH must end before the line does.
  function automatic logic cfg_valid(input cfg_t c);
    logic ok;
    ok = (c.period >= CFG_CNT_W'(2)) && (c.line_len >= CFG_LINE_W'(2)) &&
         (c.sh_len != '0) && (c.sh_len < c.line_len);
    for (int k = 0; k < CFG_NUM_CH; k++) begin
      if ((c.rise[k] >= c.period) || (c.fall[k] >= c.period)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ccd_timing_gen_if.sv
// Config bus and timing outputs between the register block (master) and the
// timing generator (slave).
interface ccd_timing_gen_if #(
  parameter int CNT_W  = ccd_timing_pkg::CFG_CNT_W,
  parameter int LINE_W = ccd_timing_pkg::CFG_LINE_W,
  parameter int NUM_CH = ccd_timing_pkg::CFG_NUM_CH
);

  logic                    en;
  logic                    cfg_load;
  logic [CNT_W-1:0]        cfg_period;
  logic [NUM_CH*CNT_W-1:0] cfg_rise;
  logic [NUM_CH*CNT_W-1:0] cfg_fall;
  logic [NUM_CH-1:0]       cfg_pol;
  logic [NUM_CH-1:0]       cfg_hold;
  logic [LINE_W-1:0]       cfg_line_len;
  logic [LINE_W-1:0]       cfg_sh_len;
  logic [NUM_CH-1:0]       ph;
  logic                    sh;
  logic                    pix_start;
  logic                    line_start;
  logic                    cfg_err;

  modport master (
    output en, cfg_load, cfg_period, cfg_rise, cfg_fall, cfg_pol, cfg_hold,
           cfg_line_len, cfg_sh_len,
    input  ph, sh, pix_start, line_start, cfg_err
  );

  modport slave (
    input  en, cfg_load, cfg_period, cfg_rise, cfg_fall, cfg_pol, cfg_hold,
           cfg_line_len, cfg_sh_len,
    output ph, sh, pix_start, line_start, cfg_err
  );

endinterface

// File: rtl/ccd_phase_ch.sv
// One pixel-rate phase output: window compare against the pixel counter,
// SH hold override, polarity and output register.
module ccd_phase_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sh_next,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] rise,
  input  logic [CNT_W-1:0] fall,
  input  logic             pol,
  input  logic             hold,
  output logic             ph
);

  logic win;
  logic ph_d, ph_q;

  // rise > fall describes a window that wraps through cnt == 0.
  always_comb begin
    win = 1'b0;
    if (rise < fall) begin
      win = (cnt >= rise) && (cnt < fall);
    end else if (rise > fall) begin
      win = (cnt >= rise) || (cnt < fall);
    end
    ph_d = pol ^ (en && win && !(sh_next && hold));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph_q <= 1'b0;
    else        ph_q <= ph_d;
  end

  assign ph = ph_q;

endmodule

// File: rtl/ccd_timing_gen.sv
// CCD/AFE timing generator: pixel/line counters, validated pending/active
// shadow configuration, SH pulse, markers and NUM_CH phase channels.
module ccd_timing_gen
  import ccd_timing_pkg::*;
#(
  parameter int CNT_W  = CFG_CNT_W,
  parameter int LINE_W = CFG_LINE_W,
  parameter int NUM_CH = CFG_NUM_CH
) (
  input logic             sys_clk,
  input logic             rst_n,
  ccd_timing_gen_if.slave bus
);

  cfg_t              cfg_in;
  cfg_t              act_d, act_q;
  cfg_t              pend_cfg_d, pend_cfg_q;
  logic              pend_d, pend_q;
  logic              err_d, err_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [LINE_W-1:0] pix_d, pix_q;
  logic              sh_d, sh_q;
  logic              pix_start_d, pix_start_q;
  logic              line_start_d, line_start_q;
  logic              cnt_wrap;
  logic [NUM_CH-1:0] ph;

  always_comb begin
    cfg_in          = CFG_RESET;
    cfg_in.period   = bus.cfg_period;
    cfg_in.rise     = bus.cfg_rise;
    cfg_in.fall     = bus.cfg_fall;
    cfg_in.pol      = bus.cfg_pol;
    cfg_in.hold     = bus.cfg_hold;
    cfg_in.line_len = bus.cfg_line_len;
    cfg_in.sh_len   = bus.cfg_sh_len;
  end

  // Pending set only reaches the active set on the last cycle of a period
  // (or at once when idle), so no period ever mixes two configurations.
  always_comb begin
    act_d      = act_q;
    pend_cfg_d = pend_cfg_q;
    pend_d     = pend_q;
    err_d      = err_q;
    cnt_d      = '0;
    pix_d      = '0;
    cnt_wrap   = (cnt_q >= act_q.period - CNT_W'(1));

    if (pend_q && (!bus.en || cnt_wrap)) begin
      act_d  = pend_cfg_q;
      pend_d = 1'b0;
    end

    if (bus.cfg_load) begin
      if (cfg_valid(cfg_in)) begin
        pend_cfg_d = cfg_in;
        pend_d     = 1'b1;
        err_d      = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (bus.en) begin
      if (cnt_wrap) begin
        cnt_d = '0;
        pix_d = (pix_q >= act_q.line_len - LINE_W'(1)) ? '0 : pix_q + LINE_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        pix_d = pix_q;
      end
    end

    sh_d         = bus.en && (pix_q < act_q.sh_len);
    pix_start_d  = bus.en && (cnt_q == '0);
    line_start_d = pix_start_d && (pix_q == '0);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q        <= CFG_RESET;
      pend_cfg_q   <= CFG_RESET;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      pix_q        <= '0;
      sh_q         <= 1'b0;
      pix_start_q  <= 1'b0;
      line_start_q <= 1'b0;
    end else begin
      act_q        <= act_d;
      pend_cfg_q   <= pend_cfg_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      pix_q        <= pix_d;
      sh_q         <= sh_d;
      pix_start_q  <= pix_start_d;
      line_start_q <= line_start_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ccd_phase_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (sys_clk),
      .rst_n   (rst_n),
      .en      (bus.en),
      .sh_next (sh_d),
      .cnt     (cnt_q),
      .rise    (act_q.rise[k]),
      .fall    (act_q.fall[k]),
      .pol     (act_q.pol[k]),
      .hold    (act_q.hold[k]),
      .ph      (ph[k])
    );
  end

  assign bus.ph         = ph;
  assign bus.sh         = sh_q;
  assign bus.pix_start  = pix_start_q;
  assign bus.line_start = line_start_q;
  assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_ccd_timing_gen.sv
// Directed bench for ccd_timing_gen: table of phase-window vectors plus
// hand-written SH/hold, reconfiguration, error and reset sequences.
module tb_ccd_timing_gen;

  localparam int CNT_W  = 8;
  localparam int LINE_W = 16;
  localparam int NUM_CH = 6;

  logic sys_clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 sys_clk = ~sys_clk;

  ccd_timing_gen_if #(.CNT_W(CNT_W), .LINE_W(LINE_W), .NUM_CH(NUM_CH)) bus ();

  ccd_timing_gen #(.CNT_W(CNT_W), .LINE_W(LINE_W), .NUM_CH(NUM_CH)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          ch;
    int          period;
    int          rise;
    int          fall;
    bit          pol;
    logic [15:0] pat;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input int period, input int line_len, input int sh_len,
                                input int ch, input int rise, input int fall,
                                input bit pol, input bit hold);
    bus.cfg_period   = CNT_W'(period);
    bus.cfg_rise     = '0;
    bus.cfg_fall     = '0;
    bus.cfg_pol      = '0;
    bus.cfg_hold     = '0;
    bus.cfg_rise[ch*CNT_W +: CNT_W] = CNT_W'(rise);
    bus.cfg_fall[ch*CNT_W +: CNT_W] = CNT_W'(fall);
    bus.cfg_pol[ch]  = pol;
    bus.cfg_hold[ch] = hold;
    bus.cfg_line_len = LINE_W'(line_len);
    bus.cfg_sh_len   = LINE_W'(sh_len);
  endtask

  task automatic load_idle();
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    check_output("load_err", 32'(bus.cfg_err), 32'd0);
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int c, pix;
    logic [NUM_CH-1:0] e;
    logic sh_e, ph_e, ps_e, err_e;

    vecs[0] = '{ch:0, period:5,  rise:0,  fall:3, pol:1'b0, pat:16'h0007};
    vecs[1] = '{ch:1, period:8,  rise:6,  fall:2, pol:1'b1, pat:16'h003C};
    vecs[2] = '{ch:2, period:4,  rise:1,  fall:1, pol:1'b0, pat:16'h0000};
    vecs[3] = '{ch:3, period:4,  rise:1,  fall:1, pol:1'b1, pat:16'h000F};
    vecs[4] = '{ch:4, period:10, rise:3,  fall:7, pol:1'b0, pat:16'h0078};
    vecs[5] = '{ch:5, period:16, rise:15, fall:1, pol:1'b0, pat:16'h8001};
    vecs[6] = '{ch:0, period:2,  rise:1,  fall:0, pol:1'b0, pat:16'h0002};

    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.cfg_load = 1'b0;
    apply_stimulus(4, 2, 1, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) step();
    check_output("rst_ph", 32'(bus.ph), 32'd0);
    check_output("rst_sh", 32'(bus.sh), 32'd0);
    check_output("rst_pix_start", 32'(bus.pix_start), 32'd0);
    check_output("rst_line_start", 32'(bus.line_start), 32'd0);
    check_output("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Phase window table: output cycle i reflects cnt = i mod period.
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].period, 100, 1, vecs[v].ch, vecs[v].rise, vecs[v].fall,
                     vecs[v].pol, 1'b0);
      load_idle();
      bus.en = 1'b1;
      for (int i = 0; i < 2 * vecs[v].period; i++) begin
        step();
        c = i % vecs[v].period;
        e = '0;
        e[vecs[v].ch] = vecs[v].pat[c];
        check_output($sformatf("vec%0d_ph_c%0d", v, c), 32'(bus.ph), 32'(e));
        check_output($sformatf("vec%0d_pix_start_c%0d", v, c), 32'(bus.pix_start), 32'(c == 0));
      end
      bus.en = 1'b0;
      step();
      e = '0;
      e[vecs[v].ch] = vecs[v].pol;
      check_output($sformatf("vec%0d_idle_ph", v), 32'(bus.ph), 32'(e));
    end

    // SH pulse with hold on ch0: period 5, line of 4 pixels, SH one pixel.
    apply_stimulus(5, 4, 1, 0, 0, 3, 1'b0, 1'b1);
    load_idle();
    bus.en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      c    = i % 5;
      pix  = (i / 5) % 4;
      sh_e = (pix == 0);
      ph_e = (c < 3) && !sh_e;
      check_output($sformatf("hold_sh_i%0d", i), 32'(bus.sh), 32'(sh_e));
      check_output($sformatf("hold_ph_i%0d", i), 32'(bus.ph), 32'(ph_e));
      check_output($sformatf("hold_line_start_i%0d", i), 32'(bus.line_start), 32'((i % 20) == 0));
    end
    bus.en = 1'b0;
    step();

    // Mid-period reconfiguration 5 -> 10, then a rejected and an accepted load.
    apply_stimulus(5, 100, 1, 0, 0, 3, 1'b0, 1'b0);
    load_idle();
    bus.en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.cfg_load = 1'b0;
      if (i == 7) begin
        apply_stimulus(10, 100, 1, 0, 0, 6, 1'b0, 1'b0);
        bus.cfg_load = 1'b1;
      end
      if (i == 22) begin
        apply_stimulus(10, 100, 1, 0, 10, 6, 1'b0, 1'b0);
        bus.cfg_load = 1'b1;
      end
      if (i == 32) begin
        apply_stimulus(10, 100, 1, 0, 0, 6, 1'b0, 1'b0);
        bus.cfg_load = 1'b1;
      end
      step();
      if (i < 10) begin
        c    = i % 5;
        ph_e = (c < 3);
      end else begin
        c    = (i - 10) % 10;
        ph_e = (c < 6);
      end
      ps_e  = (c == 0);
      err_e = (i >= 22) && (i < 32);
      check_output($sformatf("reconf_ph_i%0d", i), 32'(bus.ph), 32'(ph_e));
      check_output($sformatf("reconf_pix_start_i%0d", i), 32'(bus.pix_start), 32'(ps_e));
      check_output($sformatf("reconf_cfg_err_i%0d", i), 32'(bus.cfg_err), 32'(err_e));
    end
    bus.cfg_load = 1'b0;
    bus.en = 1'b0;
    step();

    // en drop at cnt 2, restart, pending load, then async reset mid-line.
    apply_stimulus(5, 4, 1, 0, 0, 3, 1'b1, 1'b0);
    load_idle();
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output($sformatf("enlow_run_ph_i%0d", i), 32'(bus.ph), 32'd0);
    end
    check_output("enlow_run_sh", 32'(bus.sh), 32'd1);
    bus.en = 1'b0;
    step();
    check_output("enlow_idle_ph", 32'(bus.ph), 32'd1);
    check_output("enlow_idle_sh", 32'(bus.sh), 32'd0);
    check_output("enlow_idle_pix_start", 32'(bus.pix_start), 32'd0);
    bus.en = 1'b1;
    repeat (7) step();
    apply_stimulus(7, 4, 1, 0, 0, 3, 1'b1, 1'b0);
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    step();
    check_output("prereset_ph", 32'(bus.ph), 32'd1);
    rst_n = 1'b0;
    #2;
    check_output("async_rst_ph", 32'(bus.ph), 32'd0);
    check_output("async_rst_sh", 32'(bus.sh), 32'd0);
    check_output("async_rst_pix_start", 32'(bus.pix_start), 32'd0);
    check_output("async_rst_line_start", 32'(bus.line_start), 32'd0);
    check_output("async_rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      c   = i % 4;
      pix = (i / 4) % 2;
      check_output($sformatf("postrst_ph_i%0d", i), 32'(bus.ph), 32'd0);
      check_output($sformatf("postrst_pix_start_i%0d", i), 32'(bus.pix_start), 32'(c == 0));
      check_output($sformatf("postrst_sh_i%0d", i), 32'(bus.sh), 32'(pix == 0));
      check_output($sformatf("postrst_line_start_i%0d", i), 32'(bus.line_start), 32'((i % 8) == 0));
    end
    bus.en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
